ahb_sram_subordinate: RTL and testbench



---
 rtl/ahb_sram_subordinate_if.sv | 29 ++
 rtl/ahb_sram_subordinate.sv | 191 +++++++++++++++++++
 tb/tb_ahb_sram_subordinate.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_sram_subordinate_if.sv
// AHB-Lite bus bundle between a manager and ahb_sram_subordinate.
// Signals:
//   HSEL, HADDR, HTRANS, HSIZE, HWRITE, HWDATA  manager -> subordinate
//   HRDATA, HREADY, HRESP                       subordinate -> manager
// Modports: master (manager side), slave (subordinate side).
interface ahb_sram_subordinate_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) ();
  logic                  HSEL;
  logic [ADDR_WIDTH-1:0] HADDR;
  logic [1:0]            HTRANS;
  logic [2:0]            HSIZE;
  logic                  HWRITE;
  logic [DATA_WIDTH-1:0] HWDATA;
  logic [DATA_WIDTH-1:0] HRDATA;
  logic                  HREADY;
  logic                  HRESP;

  modport master (
    output HSEL, HADDR, HTRANS, HSIZE, HWRITE, HWDATA,
    input  HRDATA, HREADY, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HSIZE, HWRITE, HWDATA,
    output HRDATA, HREADY, HRESP
  );
endinterface

// File: rtl/ahb_sram_subordinate.sv
// AHB-Lite subordinate backed by an on-chip SRAM word array.
// Decodes address phases, optionally inserts wait states, returns read data,
// commits byte-laned writes and answers bad transfers with a two-cycle ERROR.
//
// Ports:
//   clk    in   clock
//   reset  in   asynchronous active-low reset (control state only; array is not reset)
//   bus    slave modport of ahb_sram_subordinate_if
//            in : HSEL, HADDR, HTRANS, HSIZE, HWRITE, HWDATA
//            out: HRDATA, HREADY, HRESP (all decoded from registered state)
//
// Build option:
//   AHB_SRAM_WAIT_EN  when defined, WAIT_STATES wait cycles precede every good
//                     data phase; when undefined every good transfer is zero-wait.
module ahb_sram_subordinate #(
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter int unsigned           ADDR_WIDTH  = 32,
  parameter int unsigned           MEM_DEPTH   = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int unsigned           WAIT_STATES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  ahb_sram_subordinate_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(MEM_DEPTH);

  if (DATA_WIDTH != 32) begin : g_bad_data_width
    $error("ahb_sram_subordinate: only DATA_WIDTH 32 is supported");
  end
  if (WAIT_STATES > 15) begin : g_bad_wait_states
    $error("ahb_sram_subordinate: WAIT_STATES must be 0..15");
  end

  typedef enum logic [2:0] {
    ST_IDLE,
`ifdef AHB_SRAM_WAIT_EN
    ST_WAIT,
`endif
    ST_XFER,
    ST_ERR1,
    ST_ERR2
  } state_t;

  state_t                state_q, state_d;
  logic [IDX_W+1:0]      addr_q;
  logic [2:0]            size_q;
  logic                  write_q;
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic                  ready;
  logic                  accept;
  logic                  in_range;
  logic                  bad_size;
  logic                  misaligned;
  logic                  xfer_err;
  logic [3:0]            byte_en;
  logic                  mem_we;
  logic                  unused_htrans0;

  assign unused_htrans0 = bus.HTRANS[0];

  // Acceptance uses the registered ready decode, so no input reaches the outputs.
  assign accept = bus.HSEL && bus.HTRANS[1] && ready;

  // BASE_ADDR is aligned to the array size, so the range test reduces to
  // matching the address bits above the word index.
  assign in_range = (bus.HADDR[ADDR_WIDTH-1:IDX_W+2] == BASE_ADDR[ADDR_WIDTH-1:IDX_W+2]);

  always_comb begin
    bad_size   = 1'b0;
    misaligned = 1'b0;
    case (bus.HSIZE)
      3'b000:  misaligned = 1'b0;
      3'b001:  misaligned = bus.HADDR[0];
      3'b010:  misaligned = |bus.HADDR[1:0];
      default: bad_size   = 1'b1;
    endcase
  end

  assign xfer_err = !in_range || bad_size || misaligned;

`ifdef AHB_SRAM_WAIT_EN
  logic [3:0] wait_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt <= '0;
    end else if (accept) begin
      wait_cnt <= 4'(WAIT_STATES);
    end else if (state_q == ST_WAIT && wait_cnt != '0) begin
      wait_cnt <= wait_cnt - 4'd1;
    end
  end
`endif

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = ST_IDLE;
    case (state_q)
      ST_IDLE, ST_XFER, ST_ERR2: begin
        if (!accept) begin
          state_d = ST_IDLE;
        end else if (xfer_err) begin
          state_d = ST_ERR1;
        end else begin
`ifdef AHB_SRAM_WAIT_EN
          state_d = (WAIT_STATES > 0) ? ST_WAIT : ST_XFER;
`else
          state_d = ST_XFER;
`endif
        end
      end
`ifdef AHB_SRAM_WAIT_EN
      ST_WAIT: state_d = (wait_cnt > 4'd1) ? ST_WAIT : ST_XFER;
`endif
      ST_ERR1: state_d = ST_ERR2;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    ready      = 1'b1;
    bus.HRESP  = 1'b0;
    bus.HRDATA = '0;
    case (state_q)
`ifdef AHB_SRAM_WAIT_EN
      ST_WAIT: ready = 1'b0;
`endif
      ST_XFER: bus.HRDATA = mem[addr_q[IDX_W+1:2]];
      ST_ERR1: begin
        ready     = 1'b0;
        bus.HRESP = 1'b1;
      end
      ST_ERR2: bus.HRESP = 1'b1;
      default: ;
    endcase
  end

  assign bus.HREADY = ready;

  // Address-phase capture
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q  <= '0;
      size_q  <= '0;
      write_q <= 1'b0;
    end else if (accept) begin
      addr_q  <= bus.HADDR[IDX_W+1:0];
      size_q  <= bus.HSIZE;
      write_q <= bus.HWRITE;
    end
  end

  always_comb begin
    case (size_q)
      3'b000: begin
        byte_en = '0;
        byte_en[addr_q[1:0]] = 1'b1;
      end
      3'b001:  byte_en = addr_q[1] ? 4'b1100 : 4'b0011;
      default: byte_en = '1;
    endcase
  end

  // Only good transfers ever reach XFER. Gating with reset keeps a reset that
  // coincides with the final edge from committing the write.
  assign mem_we = reset && (state_q == ST_XFER) && write_q;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (byte_en[b]) begin
          mem[addr_q[IDX_W+1:2]][8*b +: 8] <= bus.HWDATA[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_ahb_sram_subordinate.sv
module tb_ahb_sram_subordinate;

  localparam int unsigned MEM_DEPTH = 1024;
  localparam logic [31:0] BASE      = 32'h0000_0000;
  localparam int unsigned WS        = 2;
`ifdef AHB_SRAM_WAIT_EN
  localparam int unsigned W = WS;
`else
  localparam int unsigned W = 0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ahb_sram_subordinate_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  ahb_sram_subordinate #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (32),
    .MEM_DEPTH  (MEM_DEPTH),
    .BASE_ADDR  (BASE),
    .WAIT_STATES(WS)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic [1:0]  trans;
    int unsigned gap;
  } xfer_t;

  xfer_t       q[$];
  logic [31:0] model [MEM_DEPTH];
  bit          known [MEM_DEPTH][4];
  logic [31:0] last_rdata;
  int          checks = 0;
  int          errors = 0;

  // Reference rules
  function automatic bit is_err(input xfer_t t);
    if (t.addr < BASE || t.addr >= BASE + 32'(MEM_DEPTH * 4)) return 1'b1;
    if (t.size > 3'd2) return 1'b1;
    if (t.size == 3'd1 && (t.addr % 2) != 0) return 1'b1;
    if (t.size == 3'd2 && (t.addr % 4) != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void model_write(input xfer_t t);
    int unsigned idx  = (t.addr - BASE) / 4;
    int unsigned lane = t.addr % 4;
    for (int unsigned b = 0; b < 4; b++) begin
      if (t.size == 3'd2 || (t.size == 3'd0 && b == lane) || (t.size == 3'd1 && b / 2 == lane / 2)) begin
        model[idx][8*b +: 8] = t.wdata[8*b +: 8];
        known[idx][b] = 1'b1;
      end
    end
  endfunction

  function automatic xfer_t mk(input bit wr, input logic [31:0] addr, input logic [2:0] size,
                               input logic [31:0] wdata, input int unsigned gap);
    xfer_t t;
    t.wr = wr; t.addr = addr; t.size = size; t.wdata = wdata; t.trans = 2'b10; t.gap = gap;
    return t;
  endfunction

  task automatic drive_idle_noise();
    case ($urandom_range(0, 2))
      0:       begin bus.HSEL = 1'b0; bus.HTRANS = 2'b10; end
      1:       begin bus.HSEL = 1'b1; bus.HTRANS = 2'b00; end
      default: begin bus.HSEL = 1'b1; bus.HTRANS = 2'b01; end
    endcase
    bus.HADDR  = $urandom & 32'h0000_0FFC;
    bus.HWRITE = 1'($urandom_range(0, 1));
    bus.HSIZE  = 3'b010;
  endtask

  // Pipelined manager driving the queue; every cycle is compared with the
  // outputs the reference rules predict for the data phase in progress.
  task automatic run_bus(input int unsigned max_cycles, output int unsigned used);
    xfer_t       dp;
    bit          dp_v = 1'b0;
    int unsigned dp_cyc = 0;
    int unsigned gap_left;
    int unsigned cyc = 0;
    bit          exp_rdy, exp_resp, chk_rd;
    logic [31:0] exp_rd;
    int unsigned idx;
    gap_left = (q.size() > 0) ? q[0].gap : 0;
    while ((q.size() > 0 || dp_v) && cyc < max_cycles) begin
      @(negedge clk);
      cyc++;
      exp_rdy = 1'b1; exp_resp = 1'b0; exp_rd = '0; chk_rd = 1'b1;
      if (dp_v) begin
        dp_cyc++;
        if (is_err(dp)) begin
          exp_resp = 1'b1;
          exp_rdy  = (dp_cyc >= 2);
        end else begin
          exp_rdy = (dp_cyc > W);
          if (exp_rdy) begin
            if (dp.wr) begin
              chk_rd = 1'b0;
            end else begin
              idx    = (dp.addr - BASE) / 4;
              exp_rd = model[idx];
              chk_rd = known[idx][0] && known[idx][1] && known[idx][2] && known[idx][3];
            end
          end
        end
      end
      checks++;
      if (bus.HREADY !== exp_rdy)
        begin errors++; $display("FAIL hready cyc=%0d addr=%h: got %b expected %b", cyc, dp.addr, bus.HREADY, exp_rdy); end
      checks++;
      if (bus.HRESP !== exp_resp)
        begin errors++; $display("FAIL hresp cyc=%0d addr=%h: got %b expected %b", cyc, dp.addr, bus.HRESP, exp_resp); end
      if (chk_rd) begin
        checks++;
        if (bus.HRDATA !== exp_rd)
          begin errors++; $display("FAIL hrdata cyc=%0d addr=%h: got %h expected %h", cyc, dp.addr, bus.HRDATA, exp_rd); end
      end
      bus.HWDATA = dp_v ? dp.wdata : $urandom;
      if (dp_v && exp_rdy) begin
        if (!is_err(dp) && dp.wr) model_write(dp);
        if (!is_err(dp) && !dp.wr) last_rdata = bus.HRDATA;
        dp_v = 1'b0;
      end
      if (q.size() > 0 && gap_left == 0) begin
        bus.HSEL = 1'b1; bus.HTRANS = q[0].trans; bus.HADDR = q[0].addr;
        bus.HSIZE = q[0].size; bus.HWRITE = q[0].wr;
        if (exp_rdy) begin
          dp = q.pop_front();
          dp_v = 1'b1;
          dp_cyc = 0;
          gap_left = (q.size() > 0) ? q[0].gap : 0;
        end
      end else begin
        drive_idle_noise();
        if (exp_rdy && gap_left > 0) gap_left--;
      end
    end
    if (q.size() > 0 || dp_v) begin
      checks++; errors++;
      $display("FAIL bus_timeout: got %0d cycles pending, required completion within %0d", cyc, max_cycles);
      q.delete();
    end
    used = cyc;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive_idle_noise();
    bus.HWDATA = '0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive_idle_noise();
      checks++;
      if (bus.HREADY !== 1'b1) begin errors++; $display("FAIL reset_hready: got %b expected 1", bus.HREADY); end
      checks++;
      if (bus.HRESP !== 1'b0) begin errors++; $display("FAIL reset_hresp: got %b expected 0", bus.HRESP); end
      checks++;
      if (bus.HRDATA !== 32'h0) begin errors++; $display("FAIL reset_hrdata: got %h expected 0", bus.HRDATA); end
    end
  endtask

  task automatic test_word_rw();
    int unsigned used;
    q.push_back(mk(1'b1, 32'h10, 3'd2, 32'hDEAD_BEEF, 0));
    q.push_back(mk(1'b0, 32'h10, 3'd2, 32'h0, 0));
    run_bus(100, used);
    checks++;
    if (last_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL word_readback: got %h expected deadbeef", last_rdata); end
  endtask

  task automatic test_byte_write();
    int unsigned used;
    logic [31:0] junk = $urandom;
    q.push_back(mk(1'b1, 32'h10, 3'd2, 32'h1122_3344, 1));
    q.push_back(mk(1'b1, 32'h13, 3'd0, {8'hAA, junk[23:0]}, 0));
    q.push_back(mk(1'b0, 32'h10, 3'd2, 32'h0, 0));
    run_bus(100, used);
    checks++;
    if (last_rdata !== 32'hAA22_3344) begin errors++; $display("FAIL byte_merge: got %h expected aa223344", last_rdata); end
    q.push_back(mk(1'b1, 32'h16, 3'd1, {16'h5566, junk[15:0]}, 0));
    q.push_back(mk(1'b1, 32'h14, 3'd2, 32'h0000_0000, 0));
    q.push_back(mk(1'b1, 32'h16, 3'd1, {16'h5566, junk[15:0]}, 0));
    q.push_back(mk(1'b0, 32'h14, 3'd2, 32'h0, 0));
    run_bus(100, used);
    checks++;
    if (last_rdata !== 32'h5566_0000) begin errors++; $display("FAIL half_merge: got %h expected 55660000", last_rdata); end
  endtask

  task automatic test_error();
    int unsigned used;
    q.push_back(mk(1'b1, 32'hFFC, 3'd2, 32'hCAFE_F00D, 0));
    q.push_back(mk(1'b0, 32'h1000, 3'd2, 32'h0, 0));
    q.push_back(mk(1'b1, 32'h1000, 3'd2, 32'h1111_1111, 0));
    q.push_back(mk(1'b1, 32'hFFE, 3'd2, 32'h2222_2222, 0));
    q.push_back(mk(1'b1, 32'hFFD, 3'd1, 32'h3333_3333, 0));
    q.push_back(mk(1'b1, 32'hFFC, 3'd3, 32'h4444_4444, 2));
    q.push_back(mk(1'b0, 32'hFFC, 3'd2, 32'h0, 0));
    run_bus(200, used);
    checks++;
    if (last_rdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL error_no_write: got %h expected cafef00d", last_rdata); end
  endtask

  task automatic test_back_to_back();
    int unsigned used;
    logic [31:0] data [16];
    for (int i = 0; i < 16; i++) begin
      data[i] = $urandom;
      q.push_back(mk(1'b1, 32'h40 + 32'(4 * i), 3'd2, data[i], 0));
      if (i > 0) q[q.size() - 1].trans = 2'b11;
    end
    for (int i = 0; i < 16; i++) begin
      q.push_back(mk(1'b0, 32'h40 + 32'(4 * i), 3'd2, 32'h0, 0));
      if (i > 0) q[q.size() - 1].trans = 2'b11;
    end
    run_bus(1000, used);
    checks++;
    if (used !== 1 + 32 * (1 + W)) begin errors++; $display("FAIL b2b_cycles: got %0d expected %0d", used, 1 + 32 * (1 + W)); end
    checks++;
    if (last_rdata !== data[15]) begin errors++; $display("FAIL b2b_last: got %h expected %h", last_rdata, data[15]); end
  endtask

  task automatic test_random();
    int unsigned used;
    xfer_t t;
    for (int i = 0; i < 64; i++) q.push_back(mk(1'b1, 32'h100 + 32'(4 * i), 3'd2, $urandom, 0));
    run_bus(1000, used);
    for (int i = 0; i < 120; i++) begin
      t.wr = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 9))
        0:       t.addr = 32'h1000 + 32'($urandom_range(0, 255) * 4);
        1:       t.addr = 32'hFFFF_FFFC;
        default: t.addr = 32'h100 + 32'($urandom_range(0, 255));
      endcase
      t.size = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      if ($urandom_range(0, 3) != 0) begin
        if (t.size == 3'd1) t.addr[0] = 1'b0;
        if (t.size == 3'd2) t.addr[1:0] = 2'b00;
      end
      t.wdata = $urandom;
      t.trans = 2'($urandom_range(2, 3));
      t.gap   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
      q.push_back(t);
    end
    run_bus(3000, used);
  endtask

  task automatic test_reset_mid_write();
    int unsigned used;
    q.push_back(mk(1'b1, 32'h20, 3'd2, 32'h0BAD_F00D, 0));
    run_bus(100, used);
    @(negedge clk);
    bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HADDR = 32'h20; bus.HSIZE = 3'd2; bus.HWRITE = 1'b1;
    @(negedge clk);
    bus.HWDATA = 32'h1234_5678;
    drive_idle_noise();
    checks++;
    if (bus.HREADY !== (W == 0)) begin errors++; $display("FAIL mid_dataphase_hready: got %b expected %b", bus.HREADY, W == 0); end
    reset = 1'b0;
    #1;
    checks++;
    if (bus.HREADY !== 1'b1) begin errors++; $display("FAIL async_reset_hready: got %b expected 1", bus.HREADY); end
    @(negedge clk);
    checks++;
    if (bus.HREADY !== 1'b1 || bus.HRESP !== 1'b0)
      begin errors++; $display("FAIL reset_next_cycle: got ready=%b resp=%b expected ready=1 resp=0", bus.HREADY, bus.HRESP); end
    reset = 1'b1;
    q.push_back(mk(1'b0, 32'h20, 3'd2, 32'h0, 1));
    run_bus(100, used);
    checks++;
    if (last_rdata !== 32'h0BAD_F00D) begin errors++; $display("FAIL reset_discard_write: got %h expected 0badf00d", last_rdata); end
  endtask

  initial begin
    for (int i = 0; i < MEM_DEPTH; i++) begin
      model[i] = '0;
      for (int b = 0; b < 4; b++) known[i][b] = 1'b0;
    end
    last_rdata = '0;
    test_reset();
    test_word_rw();
    test_byte_write();
    test_error();
    test_back_to_back();
    test_random();
    test_reset_mid_write();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
